pool_ctrl: RTL and testbench
============================

Name: pool_ctrl

Overview:
- Sequences the 2x2 max-pooling unit over CH feature-map channels stored back-to-back in a shared feature memory.
- Per channel: reads the 2*SIZE x 2*SIZE input tile, streams it into the pooling unit in that unit's load format, and captures the SIZE x SIZE pooled results and 2-bit argmax history into output memories.
- Sits between the layer sequencer (start/done) and the feature/output SRAMs.

Parameters:
SIZE, 3, pooled output side; input tile side is IN_SIZE = 2*SIZE
CH, 4, number of channels processed per start
AW, 16, memory address width
DW, 16, data word width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request; accepted only in IDLE
in_base  in  AW  channel-0 input word address; sampled on accepted start
out_base  in  AW  channel-0 output word address; sampled on accepted start
busy  out  1  high from the cycle after accepted start through FINISH
done  out  1  one-cycle pulse in FINISH
ch_idx  out  8  current channel index
rd_en  out  1  feature memory read strobe; data returns next cycle
rd_addr  out  AW  feature memory read address
rd_data  in  DW  feature memory read data
pl_clr_n  out  1  pooling-unit reset, active-low
pl_load  out  1  pooling-unit load strobe
pl_in  out  DW  pooling-unit load data
pl_result  in  DW  pooled value
pl_addr  in  16  pooled element index within the channel, 0..SIZE*SIZE-1
pl_history  in  2  argmax position (0 TL, 1 TR, 2 BL, 3 BR)
pl_reg_sig  in  1  pooling output valid
pl_done  in  1  pooling-unit completion pulse
wr_en, wr_addr[AW], wr_data[DW]  out  result memory write port
hist_wr_en, hist_wr_addr[AW], hist_wr_data[2]  out  history memory write port

Behaviour:
- Reset values: busy=0, done=0, rd_en=0, pl_load=0, wr_en=0, hist_wr_en=0, ch_idx=0; all address/data outputs 0; state IDLE.
- pl_clr_n = ~(rst | state==CLEAR), so the pooling unit is held in reset whenever this block is.
- States and transitions:
  - IDLE: on start, latch in_base/out_base, set ch=0, go to CLEAR.
  - CLEAR: one cycle, pl_clr_n=0. Then go to LOAD.
  - LOAD: row r = 0..IN_SIZE-1, beat b = 0..IN_SIZE+1 (IN_SIZE+2 beats per row). Each beat asserts rd_en with rd_addr = in_base + ch*IN_SIZE^2 + r*IN_SIZE + min(b, IN_SIZE-1). The last word of each row is therefore read three times.
  - LOAD data path: pl_load is rd_en delayed one cycle, and pl_in = rd_data. Total pl_load pulses per channel = IN_SIZE*(IN_SIZE+2), contiguous with no gaps. After the final read, go to DRAIN.
  - DRAIN: wait for pl_done, then go to NEXT.
  - NEXT: one cycle. If ch==CH-1 go to FINISH; else ch++ and go to CLEAR.
  - FINISH: done=1 for one cycle, then IDLE.
- Capture runs in any state. Each cycle pl_reg_sig=1:
  - wr_en=1, wr_addr = out_base + ch*SIZE*SIZE + pl_addr, wr_data = pl_result.
  - Same cycle: hist_wr_en=1, hist_wr_addr = the same address, hist_wr_data = pl_history.
  - Pooling output overlaps the tail of LOAD; this is legal and needs no stall.
- Arithmetic: all address sums are modulo 2^AW. No memory backpressure; all memory writes are single-cycle.
- Boundary conditions:
  - start while busy: ignored; bases unchanged.
  - pl_done arriving before DRAIN: latched, and DRAIN exits on its next cycle.
  - rst mid-operation: returns to IDLE next cycle, drops all strobes, discards the partial channel, no done pulse.

Optional Feature:
- Macro POOL_CTRL_HIST_EN.
- Defined: history write port active as above.
- Undefined: hist_wr_en, hist_wr_addr and hist_wr_data are tied to 0, and history capture logic is removed. Result writes are unaffected.

Decomposition:
- Shared package pool_pkg holds:
  - state encoding (IDLE, CLEAR, LOAD, DRAIN, NEXT, FINISH);
  - history codes HIST_TL=0, HIST_TR=1, HIST_BL=2, HIST_BR=3;
  - helper constants IN_SIZE and TILE_WORDS = IN_SIZE^2.
- One sub-module, pool_ctrl_agen: the LOAD row/beat counters and read-address generator.

Test Plan:
- SIZE=3, CH=1, in_base=0, tile value = r*6+c (ramp 0..35) -> exactly 48 pl_load pulses. Result writes at addr 0..8 = 7,9,11,19,21,23,31,33,35; all history = 3; one done pulse.
- Descending ramp 35..0 -> results 35,33,31,23,21,19,11,9,7; all history = 0.
- All 36 words = 0x0005 -> every result 5 with history 0, confirming the tie goes to the earlier position.
- CH=2, in_base=0x40, out_base=0x100 -> channel 1 reads 0x64..0x87 and writes 0x109..0x111; pl_clr_n low exactly once before each channel; one done pulse.
- rst asserted mid-LOAD of channel 0 -> busy=0 next cycle, no further writes. A following start completes cleanly with correct results.
- start pulsed during DRAIN with different bases -> ignored; addresses use the original bases. Without POOL_CTRL_HIST_EN, hist_wr_en stays 0 throughout.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared state encoding, argmax codes and tile-size helpers for the pooling sequencer.
package pool_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LOAD   = 3'd2,
    DRAIN  = 3'd3,
    NEXT   = 3'd4,
    FINISH = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    HIST_TL = 2'd0,
    HIST_TR = 2'd1,
    HIST_BL = 2'd2,
    HIST_BR = 2'd3
  } hist_t;

  localparam int POOL_SIZE  = 3;
  localparam int IN_SIZE    = 2 * POOL_SIZE;
  localparam int TILE_WORDS = IN_SIZE * IN_SIZE;

  function automatic int in_size_of(input int size);
    return 2 * size;
  endfunction

  function automatic int tile_words_of(input int size);
    return 4 * size * size;
  endfunction

endpackage

// File: rtl/pool_ctrl_agen.sv
// Row/beat counters and feature-memory read address for one channel's LOAD phase.
// Each row takes IN_SIZE+2 beats; beats past the row end re-read the last column.
module pool_ctrl_agen
  import pool_pkg::*;
#(
  parameter int SIZE = 3,
  parameter int AW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [AW-1:0] base,
  input  logic [7:0]    ch,
  output logic [AW-1:0] addr,
  output logic          last
);

  localparam int IN   = in_size_of(SIZE);
  localparam int TILE = tile_words_of(SIZE);
  localparam int BW   = $clog2(IN + 2);
  localparam int RW   = $clog2(IN);

  localparam logic [BW-1:0] BEAT_LAST = BW'(IN + 1);
  localparam logic [BW-1:0] COL_MAX   = BW'(IN - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IN - 1);

  logic [BW-1:0] beat_q, beat_d;
  logic [RW-1:0] row_q, row_d;
  logic [BW-1:0] col;

  always_comb begin
    beat_d = beat_q;
    row_d  = row_q;
    if (!run) begin
      beat_d = '0;
      row_d  = '0;
    end else if (beat_q == BEAT_LAST) begin
      beat_d = '0;
      row_d  = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    end else begin
      beat_d = beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= '0;
      row_q  <= '0;
    end else begin
      beat_q <= beat_d;
      row_q  <= row_d;
    end
  end

  // Clamp so the two trailing beats of a row repeat the final column.
  assign col  = (beat_q > COL_MAX) ? COL_MAX : beat_q;
  assign last = run && (beat_q == BEAT_LAST) && (row_q == ROW_LAST);
  assign addr = base + AW'(ch) * AW'(TILE) + AW'(row_q) * AW'(IN) + AW'(col);

endmodule

// File: rtl/pool_ctrl.sv
// Sequences the 2x2 max-pooling unit over CH channels and captures its results.
// History write port exists only when POOL_CTRL_HIST_EN is defined; otherwise it is tied to zero.
module pool_ctrl
  import pool_pkg::*;
#(
  parameter int SIZE = 3,
  parameter int CH   = 4,
  parameter int AW   = 16,
  parameter int DW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] in_base,
  input  logic [AW-1:0] out_base,
  output logic          busy,
  output logic          done,
  output logic [7:0]    ch_idx,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          pl_clr_n,
  output logic          pl_load,
  output logic [DW-1:0] pl_in,
  input  logic [DW-1:0] pl_result,
  input  logic [15:0]   pl_addr,
  input  logic [1:0]    pl_history,
  input  logic          pl_reg_sig,
  input  logic          pl_done,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          hist_wr_en,
  output logic [AW-1:0] hist_wr_addr,
  output logic [1:0]    hist_wr_data
);

  localparam int         OUT_WORDS = SIZE * SIZE;
  localparam logic [7:0] CH_LAST   = 8'(CH - 1);

  state_t        state_q, state_d;
  logic [7:0]    ch_q, ch_d;
  logic [AW-1:0] in_base_q, in_base_d;
  logic [AW-1:0] out_base_q, out_base_d;
  logic          done_seen_q, done_seen_d;
  logic          pl_load_q, pl_load_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  logic          load_run;
  logic          agen_last;
  logic [AW-1:0] agen_addr;
  logic [AW-1:0] cap_addr;

  assign load_run = (state_q == LOAD);

  pool_ctrl_agen #(
    .SIZE (SIZE),
    .AW   (AW)
  ) u_agen (
    .clk  (clk),
    .rst  (rst),
    .run  (load_run),
    .base (in_base_q),
    .ch   (ch_q),
    .addr (agen_addr),
    .last (agen_last)
  );

  // A completion pulse that beats us to DRAIN is remembered until DRAIN consumes it.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    in_base_d   = in_base_q;
    out_base_d  = out_base_q;
    done_seen_d = done_seen_q | pl_done;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = CLEAR;
          ch_d       = '0;
          in_base_d  = in_base;
          out_base_d = out_base;
        end
      end
      CLEAR: begin
        state_d     = LOAD;
        done_seen_d = 1'b0;
      end
      LOAD: begin
        if (agen_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (pl_done || done_seen_q) begin
          state_d     = NEXT;
          done_seen_d = 1'b0;
        end
      end
      NEXT: begin
        if (ch_q == CH_LAST) begin
          state_d = FINISH;
        end else begin
          ch_d    = ch_q + 8'd1;
          state_d = CLEAR;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture is independent of the FSM: pooled output overlaps the tail of LOAD.
  assign cap_addr = pl_reg_sig ? (out_base_q + AW'(ch_q) * AW'(OUT_WORDS) + AW'(pl_addr)) : '0;

  always_comb begin
    pl_load_d = load_run;
    wr_en_d   = pl_reg_sig;
    wr_addr_d = cap_addr;
    wr_data_d = pl_reg_sig ? pl_result : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      in_base_q   <= '0;
      out_base_q  <= '0;
      done_seen_q <= 1'b0;
      pl_load_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      in_base_q   <= in_base_d;
      out_base_q  <= out_base_d;
      done_seen_q <= done_seen_d;
      pl_load_q   <= pl_load_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FINISH);
  assign ch_idx   = ch_q;
  assign rd_en    = load_run;
  assign rd_addr  = load_run ? agen_addr : '0;
  assign pl_clr_n = ~(rst | (state_q == CLEAR));
  assign pl_load  = pl_load_q;
  assign pl_in    = pl_load_q ? rd_data : '0;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

`ifdef POOL_CTRL_HIST_EN
  logic          hist_wr_en_q, hist_wr_en_d;
  logic [AW-1:0] hist_wr_addr_q, hist_wr_addr_d;
  hist_t         hist_wr_data_q, hist_wr_data_d;

  always_comb begin
    hist_wr_en_d   = pl_reg_sig;
    hist_wr_addr_d = cap_addr;
    hist_wr_data_d = pl_reg_sig ? hist_t'(pl_history) : HIST_TL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_wr_en_q   <= 1'b0;
      hist_wr_addr_q <= '0;
      hist_wr_data_q <= HIST_TL;
    end else begin
      hist_wr_en_q   <= hist_wr_en_d;
      hist_wr_addr_q <= hist_wr_addr_d;
      hist_wr_data_q <= hist_wr_data_d;
    end
  end

  assign hist_wr_en   = hist_wr_en_q;
  assign hist_wr_addr = hist_wr_addr_q;
  assign hist_wr_data = hist_wr_data_q;
`else
  logic unused_hist;
  assign unused_hist  = ^pl_history;
  assign hist_wr_en   = 1'b0;
  assign hist_wr_addr = '0;
  assign hist_wr_data = '0;
`endif

endmodule

// File: tb/tb_pool_ctrl.sv
// Scoreboard bench for pool_ctrl with a behavioural pooling unit and feature memory.
module tb_pool_ctrl;

  localparam int SIZE = 3;
  localparam int CH   = 2;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int IN   = 2 * SIZE;
  localparam int TW   = IN * IN;
  localparam int OW   = SIZE * SIZE;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] in_base = '0;
  logic [AW-1:0] out_base = '0;
  logic          busy, done;
  logic [7:0]    ch_idx;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          pl_clr_n, pl_load;
  logic [DW-1:0] pl_in;
  logic [DW-1:0] pl_result = '0;
  logic [15:0]   pl_addr = '0;
  logic [1:0]    pl_history = '0;
  logic          pl_reg_sig = 1'b0;
  logic          pl_done = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          hist_wr_en;
  logic [AW-1:0] hist_wr_addr;
  logic [1:0]    hist_wr_data;

  pool_ctrl #(.SIZE(SIZE), .CH(CH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_base(in_base), .out_base(out_base),
    .busy(busy), .done(done), .ch_idx(ch_idx),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pl_clr_n(pl_clr_n), .pl_load(pl_load), .pl_in(pl_in),
    .pl_result(pl_result), .pl_addr(pl_addr), .pl_history(pl_history),
    .pl_reg_sig(pl_reg_sig), .pl_done(pl_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .hist_wr_en(hist_wr_en), .hist_wr_addr(hist_wr_addr), .hist_wr_data(hist_wr_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  hist;
  } wr_exp_t;

  typedef struct packed {
    logic [15:0] v;
    logic [15:0] a;
    logic [1:0]  h;
  } pout_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] rd_q[$];
  wr_exp_t     wr_q[$];
  logic [15:0] mem [0:1023];
  int          done_cnt = 0;
  int          load_cnt = 0;
  int          clr_cnt = 0;
  bit          early_mode = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Max with ties resolved toward the earlier position TL, TR, BL, BR.
  function automatic logic [17:0] max4(input logic [15:0] tl, tr, bl, br);
    logic [15:0] v;
    logic [1:0]  h;
    v = tl; h = 2'd0;
    if (tr > v) begin v = tr; h = 2'd1; end
    if (bl > v) begin v = bl; h = 2'd2; end
    if (br > v) begin v = br; h = 2'd3; end
    return {v, h};
  endfunction

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[9:0]];

  // Behavioural pooling unit: consumes IN+2 beats per row, emits a row of results per row pair.
  int          lb = 0;
  int          lr = 0;
  bit          done_sent = 1'b0;
  logic [15:0] tile [0:IN-1][0:IN-1];
  pout_t       oq[$];

  always @(negedge clk) begin
    pout_t       po;
    logic [17:0] m;
    pl_reg_sig = 1'b0;
    pl_done    = 1'b0;
    if (!pl_clr_n) begin
      lb = 0; lr = 0; done_sent = 1'b0; oq.delete();
      pl_result = '0; pl_addr = '0; pl_history = '0;
    end else begin
      if (oq.size() > 0) begin
        po = oq.pop_front();
        pl_reg_sig = 1'b1; pl_result = po.v; pl_addr = po.a; pl_history = po.h;
      end else if (lr == IN && !done_sent) begin
        pl_done = 1'b1; done_sent = 1'b1;
      end
      if (early_mode && !done_sent && ch_idx == 8'(CH - 1) && lr == IN - 1 && lb == 0) begin
        pl_done = 1'b1; done_sent = 1'b1;
      end
      if (pl_load && lr < IN) begin
        if (lb < IN) tile[lr][lb] = pl_in;
        if (lb == IN + 1) begin
          if (lr % 2 == 1) begin
            for (int j = 0; j < SIZE; j++) begin
              m = max4(tile[lr-1][2*j], tile[lr-1][2*j+1], tile[lr][2*j], tile[lr][2*j+1]);
              oq.push_back('{v: m[17:2], a: 16'((lr / 2) * SIZE + j), h: m[1:0]});
            end
          end
          lb = 0; lr++;
        end else begin
          lb++;
        end
      end
    end
  end

  always @(negedge clk) begin
    wr_exp_t we;
    if (done) done_cnt++;
    if (pl_load) load_cnt++;
    if (!pl_clr_n && !rst) clr_cnt++;
    if (rd_en) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 32'(rd_en), 0);
      else chk("rd_addr", 32'(rd_addr), 32'(rd_q.pop_front()));
    end
    if (wr_en) begin
      if (wr_q.size() == 0) chk("wr_unexpected", 32'(wr_en), 0);
      else begin
        we = wr_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(we.addr));
        chk("wr_data", 32'(wr_data), 32'(we.data));
`ifdef POOL_CTRL_HIST_EN
        chk("hist_en", 32'(hist_wr_en), 1);
        chk("hist_addr", 32'(hist_wr_addr), 32'(we.addr));
        chk("hist_data", 32'(hist_wr_data), 32'(we.hist));
`endif
      end
    end
`ifndef POOL_CTRL_HIST_EN
    if (wr_en || hist_wr_en) chk("hist_tied", {13'd0, hist_wr_en, hist_wr_addr, hist_wr_data}, 0);
`endif
  end

  task automatic fill(input int mode, input int base);
    for (int i = 0; i < CH * TW; i++) begin
      case (mode)
        0:       mem[base + i] = 16'(i);
        1:       mem[base + i] = 16'(35 - (i % TW));
        2:       mem[base + i] = 16'h0005;
        default: mem[base + i] = 16'($urandom);
      endcase
    end
  endtask

  task automatic expect_job(input logic [15:0] ib, input logic [15:0] ob);
    logic [15:0] a;
    logic [17:0] m;
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < IN; r++)
        for (int b = 0; b < IN + 2; b++)
          rd_q.push_back(16'(ib + c * TW + r * IN + ((b < IN) ? b : IN - 1)));
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < SIZE; i++)
        for (int j = 0; j < SIZE; j++) begin
          a = 16'(ib + c * TW + 2 * i * IN + 2 * j);
          m = max4(mem[a[9:0]], mem[10'(a + 16'd1)], mem[10'(a + 16'(IN))], mem[10'(a + 16'(IN + 1))]);
          wr_q.push_back('{addr: 16'(ob + c * OW + i * SIZE + j), data: m[17:2], hist: m[1:0]});
        end
  endtask

  task automatic wait_rd(input logic lvl);
    int t = 0;
    while (rd_en !== lvl && t < 500) begin @(negedge clk); t++; end
    chk("rd_wait", 32'(rd_en), 32'(lvl));
  endtask

  // mode: 0 plain, 1 start pulsed in DRAIN, 2 early pl_done, 3 reset during LOAD
  task automatic run_job(input logic [15:0] ib, input logic [15:0] ob, input int mode);
    int d0, l0, c0, t;
    expect_job(ib, ob);
    d0 = done_cnt; l0 = load_cnt; c0 = clr_cnt;
    early_mode = (mode == 2);
    @(negedge clk);
    in_base = ib; out_base = ob; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_base = 16'hdead; out_base = 16'hbeef;
    chk("busy_after_start", 32'(busy), 1);
    if (mode == 3) begin
      wait_rd(1'b1);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rd_en", 32'(rd_en), 0);
      chk("rst_pl_load", 32'(pl_load), 0);
      chk("rst_wr_en", 32'(wr_en), 0);
      chk("rst_ch_idx", 32'(ch_idx), 0);
      rd_q.delete(); wr_q.delete();
      repeat (100) @(negedge clk);
      chk("rst_no_done", 32'(done_cnt - d0), 0);
      return;
    end
    if (mode == 1) begin
      wait_rd(1'b1);
      wait_rd(1'b0);
      in_base = 16'h0200; out_base = 16'h0300; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_in_drain", 32'(busy), 1);
    end
    t = 0;
    while (done !== 1'b1 && t < 4000) begin @(negedge clk); t++; end
    chk("done_reached", 32'(done), 1);
    chk("busy_at_done", 32'(busy), 1);
    repeat (20) @(negedge clk);
    chk("busy_after", 32'(busy), 0);
    chk("done_pulses", 32'(done_cnt - d0), 1);
    chk("load_pulses", 32'(load_cnt - l0), 32'(CH * IN * (IN + 2)));
    chk("clr_pulses", 32'(clr_cnt - c0), 32'(CH));
    chk("rd_left", 32'(rd_q.size()), 0);
    chk("wr_left", 32'(wr_q.size()), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy0", 32'(busy), 0);
    chk("rst_done0", 32'(done), 0);
    chk("rst_rd_en0", 32'(rd_en), 0);
    chk("rst_rd_addr0", 32'(rd_addr), 0);
    chk("rst_pl_load0", 32'(pl_load), 0);
    chk("rst_pl_in0", 32'(pl_in), 0);
    chk("rst_wr0", {15'd0, wr_en, wr_addr}, 0);
    chk("rst_wr_data0", 32'(wr_data), 0);
    chk("rst_hist0", {13'd0, hist_wr_en, hist_wr_addr, hist_wr_data}, 0);
    chk("rst_ch_idx0", 32'(ch_idx), 0);
    chk("rst_clr_n0", 32'(pl_clr_n), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_clr_n", 32'(pl_clr_n), 1);

    fill(0, 0);        run_job(16'h0000, 16'h0000, 0);
    fill(1, 0);        run_job(16'h0000, 16'h0000, 0);
    fill(2, 0);        run_job(16'h0000, 16'h0000, 0);
    fill(3, 16'h40);   run_job(16'h0040, 16'h0100, 0);
    fill(0, 0);        run_job(16'h0000, 16'h0000, 3);
                       run_job(16'h0000, 16'h0000, 0);
    fill(3, 16'h40);   run_job(16'h0040, 16'h0100, 1);
                       run_job(16'h0040, 16'h0100, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
